// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and types for the bus-matrix blocks (input stage, decoder, arbiters).
package ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Address-phase control bundle, everything except the address itself.
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ahb_ctrl_t;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_xfer(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_mtx_input_stage_if.sv
// Signal bundle around one bus-matrix input stage: master-side AHB, target-side return, forwarded phase.
interface ahb_mtx_input_stage_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  HREADYOUTS;
  logic [1:0]            HRESPS;

  logic                  addr_sel;
  logic                  HREADYM;
  logic [1:0]            HRESPM;

  logic                  trans_req;
  logic [ADDR_WIDTH-1:0] HADDRM;
  logic [1:0]            HTRANSM;
  logic                  HWRITEM;
  logic [2:0]            HSIZEM;
  logic [2:0]            HBURSTM;
  logic [3:0]            HPROTM;
  logic                  HMASTLOCKM;
  logic                  pend_tran;
  logic                  data_phase;

  // Handshake: an address phase moves to the target on a cycle where trans_req,
  // addr_sel and HREADYM are all high; until then a sampled transfer is held and
  // HREADYOUTS stays low, and the master only advances when HREADYS is high.
  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    input  addr_sel, HREADYM, HRESPM,
    output HREADYOUTS, HRESPS,
    output trans_req, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM,
    output pend_tran, data_phase
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    output addr_sel, HREADYM, HRESPM,
    input  HREADYOUTS, HRESPS,
    input  trans_req, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM,
    input  pend_tran, data_phase
  );

endinterface

// File: rtl/ahb_mtx_input_stage.sv
// Per-master input stage of the AHB matrix: holds address phases the target cannot take yet
// and inserts master-side wait states until the held transfer is granted.
module ahb_mtx_input_stage
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_mtx_input_stage_if.slave  bus
);

  logic                  sample;
  logic                  active;
  logic                  accept;
  logic                  req;
  logic                  pend_tran;
  logic                  data_phase;
  logic [ADDR_WIDTH-1:0] hold_addr;
  ahb_ctrl_t             hold_ctrl;
  ahb_ctrl_t             live_ctrl;
  ahb_ctrl_t             fwd_ctrl;
  logic [ADDR_WIDTH-1:0] fwd_addr;

  assign sample = bus.HSELS & bus.HREADYS;
  assign active = sample & is_xfer(bus.HTRANSS);
  // Reset masks the request so nothing is offered to the arbiters mid-reset.
  assign req    = ~HRESET & (pend_tran | active);
  assign accept = bus.addr_sel & bus.HREADYM & req;

  assign live_ctrl = '{
    trans: sample ? bus.HTRANSS : HTRANS_IDLE,
    write: bus.HWRITES,
    size:  bus.HSIZES,
    burst: bus.HBURSTS,
    prot:  bus.HPROTS,
    lock:  bus.HMASTLOCKS
  };

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_tran  <= 1'b0;
      data_phase <= 1'b0;
      hold_addr  <= '0;
      hold_ctrl  <= '0;
    end else begin
      if (active && !accept) begin
        pend_tran <= 1'b1;
        hold_addr <= bus.HADDRS;
        hold_ctrl <= '{
          trans: bus.HTRANSS,
          write: bus.HWRITES,
          size:  bus.HSIZES,
          burst: bus.HBURSTS,
          prot:  bus.HPROTS,
          lock:  bus.HMASTLOCKS
        };
      end else if (accept) begin
        pend_tran <= 1'b0;
      end
      if (accept) begin
        data_phase <= 1'b1;
      end else if (data_phase && bus.HREADYM) begin
        data_phase <= 1'b0;
      end
    end
  end

  // A held transfer (including a locked one) wins over whatever the master drives now.
  assign fwd_addr = pend_tran ? hold_addr : bus.HADDRS;
  assign fwd_ctrl = pend_tran ? hold_ctrl : live_ctrl;

  assign bus.trans_req  = req;
  assign bus.HADDRM     = fwd_addr;
  assign bus.HTRANSM    = fwd_ctrl.trans;
  assign bus.HWRITEM    = fwd_ctrl.write;
  assign bus.HSIZEM     = fwd_ctrl.size;
  assign bus.HBURSTM    = fwd_ctrl.burst;
  assign bus.HPROTM     = fwd_ctrl.prot;
  assign bus.HMASTLOCKM = fwd_ctrl.lock;

  assign bus.HREADYOUTS = data_phase ? bus.HREADYM : ~pend_tran;
  assign bus.HRESPS     = data_phase ? bus.HRESPM  : HRESP_OKAY;

  assign bus.pend_tran  = pend_tran;
  assign bus.data_phase = data_phase;

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// Directed bench for the matrix input stage: reset, direct grant, held grant, ERROR, INCR4 burst.
module tb_ahb_mtx_input_stage;
  import ahb_mtx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  ahb_mtx_input_stage_if #(.ADDR_WIDTH(32)) bus ();

  ahb_mtx_input_stage #(.ADDR_WIDTH(32)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_master();
    bus.HSELS      = 1'b0;
    bus.HADDRS     = 32'h0;
    bus.HTRANSS    = HTRANS_IDLE;
    bus.HWRITES    = 1'b0;
    bus.HSIZES     = 3'b010;
    bus.HBURSTS    = HBURST_SINGLE;
    bus.HPROTS     = 4'b0011;
    bus.HMASTLOCKS = 1'b0;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans,
                       input logic write, input logic [2:0] burst);
    bus.HSELS      = 1'b1;
    bus.HADDRS     = addr;
    bus.HTRANSS    = trans;
    bus.HWRITES    = write;
    bus.HSIZES     = 3'b010;
    bus.HBURSTS    = burst;
    bus.HPROTS     = 4'b0011;
    bus.HMASTLOCKS = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle_master();
    bus.HREADYS  = 1'b1;
    bus.addr_sel = 1'b0;
    bus.HREADYM  = 1'b1;
    bus.HRESPM   = HRESP_OKAY;

    // Reset held for two edges with a live NONSEQ on the bus.
    rst = 1'b1;
    drive(32'h4000_0000, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_pend", bus.pend_tran, 0);
      chk("rst_hreadyout", bus.HREADYOUTS, 1);
      chk("rst_hresp", bus.HRESPS, HRESP_OKAY);
      chk("rst_trans_req", bus.trans_req, 0);
    end
    rst = 1'b0;
    idle_master();
    step();

    // Direct grant: NONSEQ SINGLE accepted the cycle it appears.
    drive(32'h4000_0000, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE);
    bus.addr_sel = 1'b1;
    #1;
    chk("t2_trans_req", bus.trans_req, 1);
    chk("t2_htransm", bus.HTRANSM, HTRANS_NONSEQ);
    chk("t2_haddrm", bus.HADDRM, 32'h4000_0000);
    chk("t2_hreadyout", bus.HREADYOUTS, 1);
    step();
    idle_master();
    bus.addr_sel = 1'b0;
    bus.HREADYM  = 1'b0;
    bus.HREADYS  = 1'b0;
    #1;
    chk("t2_dphase", bus.data_phase, 1);
    chk("t2_no_hold", bus.pend_tran, 0);
    chk("t2_hreadyout_wait", bus.HREADYOUTS, 0);
    chk("t2_idle_fwd", bus.HTRANSM, HTRANS_IDLE);
    bus.HREADYM = 1'b1;
    bus.HREADYS = 1'b1;
    #1;
    chk("t2_hreadyout_go", bus.HREADYOUTS, 1);
    step();
    chk("t2_dphase_clr", bus.data_phase, 0);

    // Held grant: write waits three cycles for addr_sel.
    drive(32'h4000_0010, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE);
    #1;
    chk("t3_load_pend", bus.pend_tran, 0);
    chk("t3_load_req", bus.trans_req, 1);
    step();
    idle_master();
    bus.HREADYS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_pend", bus.pend_tran, 1);
      chk("t3_haddrm", bus.HADDRM, 32'h4000_0010);
      chk("t3_hwritem", bus.HWRITEM, 1);
      chk("t3_htransm", bus.HTRANSM, HTRANS_NONSEQ);
      chk("t3_hreadyout", bus.HREADYOUTS, 0);
      chk("t3_req", bus.trans_req, 1);
      step();
    end
    bus.addr_sel = 1'b1;
    #1;
    chk("t3_grant_addr", bus.HADDRM, 32'h4000_0010);
    step();
    bus.addr_sel = 1'b0;
    bus.HREADYS  = 1'b1;
    #1;
    chk("t3_pend_clr", bus.pend_tran, 0);
    chk("t3_dphase", bus.data_phase, 1);
    chk("t3_hreadyout", bus.HREADYOUTS, 1);
    step();
    chk("t3_dphase_clr", bus.data_phase, 0);

    // Two-cycle ERROR with a NONSEQ sampled behind it.
    drive(32'h4000_0020, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE);
    bus.addr_sel = 1'b1;
    step();
    drive(32'h4000_0030, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE);
    bus.addr_sel = 1'b0;
    bus.HREADYM  = 1'b0;
    bus.HRESPM   = HRESP_ERROR;
    #1;
    chk("t4_err1_resp", bus.HRESPS, HRESP_ERROR);
    chk("t4_err1_ready", bus.HREADYOUTS, 0);
    step();
    idle_master();
    bus.HREADYS = 1'b0;
    bus.HREADYM = 1'b1;
    #1;
    chk("t4_err2_resp", bus.HRESPS, HRESP_ERROR);
    chk("t4_err2_ready", bus.HREADYOUTS, 1);
    chk("t4_err2_pend", bus.pend_tran, 1);
    chk("t4_err2_haddrm", bus.HADDRM, 32'h4000_0030);
    step();
    bus.HRESPM = HRESP_OKAY;
    #1;
    chk("t4_after_pend", bus.pend_tran, 1);
    chk("t4_after_ready", bus.HREADYOUTS, 0);
    chk("t4_after_resp", bus.HRESPS, HRESP_OKAY);
    chk("t4_after_htrans", bus.HTRANSM, HTRANS_NONSEQ);
    bus.addr_sel = 1'b1;
    step();
    bus.addr_sel = 1'b0;
    bus.HREADYS  = 1'b1;
    #1;
    chk("t4_grant_pend", bus.pend_tran, 0);
    chk("t4_grant_dphase", bus.data_phase, 1);
    step();

    // INCR4 burst with one stall on beat 2.
    bus.addr_sel = 1'b1;
    drive(32'h2000_0000, HTRANS_NONSEQ, 1'b0, HBURST_INCR4);
    #1;
    chk("t5_b0_addr", bus.HADDRM, 32'h2000_0000);
    chk("t5_b0_trans", bus.HTRANSM, HTRANS_NONSEQ);
    chk("t5_b0_burst", bus.HBURSTM, HBURST_INCR4);
    step();
    drive(32'h2000_0004, HTRANS_SEQ, 1'b0, HBURST_INCR4);
    #1;
    chk("t5_b1_addr", bus.HADDRM, 32'h2000_0004);
    chk("t5_b1_trans", bus.HTRANSM, HTRANS_SEQ);
    chk("t5_b1_req", bus.trans_req, 1);
    chk("t5_b1_ready", bus.HREADYOUTS, 1);
    step();
    drive(32'h2000_0008, HTRANS_SEQ, 1'b0, HBURST_INCR4);
    bus.HREADYM = 1'b0;
    bus.HREADYS = 1'b0;
    #1;
    chk("t5_stall_ready", bus.HREADYOUTS, 0);
    chk("t5_stall_req", bus.trans_req, 0);
    chk("t5_stall_trans", bus.HTRANSM, HTRANS_IDLE);
    chk("t5_stall_pend", bus.pend_tran, 0);
    step();
    bus.HREADYM = 1'b1;
    bus.HREADYS = 1'b1;
    #1;
    chk("t5_b2_addr", bus.HADDRM, 32'h2000_0008);
    chk("t5_b2_trans", bus.HTRANSM, HTRANS_SEQ);
    chk("t5_b2_req", bus.trans_req, 1);
    step();
    drive(32'h2000_000C, HTRANS_SEQ, 1'b0, HBURST_INCR4);
    #1;
    chk("t5_b3_addr", bus.HADDRM, 32'h2000_000C);
    chk("t5_b3_trans", bus.HTRANSM, HTRANS_SEQ);
    step();
    idle_master();
    bus.addr_sel = 1'b0;
    #1;
    chk("t5_last_dphase", bus.data_phase, 1);
    chk("t5_last_pend", bus.pend_tran, 0);
    step();
    chk("t5_dphase_clr", bus.data_phase, 0);

    // Reset while a transfer is held.
    drive(32'h4000_0040, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE);
    step();
    chk("t6_pend", bus.pend_tran, 1);
    chk("t6_ready", bus.HREADYOUTS, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_req_comb", bus.trans_req, 0);
    step();
    chk("t6_rst_pend", bus.pend_tran, 0);
    chk("t6_rst_req", bus.trans_req, 0);
    chk("t6_rst_ready", bus.HREADYOUTS, 1);
    chk("t6_rst_dphase", bus.data_phase, 0);
    rst = 1'b0;
    idle_master();
    step();
    chk("t6_post_pend", bus.pend_tran, 0);
    chk("t6_post_req", bus.trans_req, 0);
    chk("t6_post_trans", bus.HTRANSM, HTRANS_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
